// File: rtl/tdc_ctrl_if.sv
// Bundles the tdc_ctrl request/launch/capture/result signals.
// The bench drives the master side and the controller takes the slave side.
interface tdc_ctrl_if #(
   parameter int N = 64
);
   localparam int RW = $clog2(N + 1);

   logic          start;
   logic          busy;
   logic          launch;
   logic [N-1:0]  dl_out;
   logic [RW-1:0] result;
   logic          overflow;
   logic          valid;
   logic          ready;
   logic [15:0]   meas_cnt;

   modport master (
      output start, dl_out, ready,
      input  busy, launch, result, overflow, valid, meas_cnt
   );

   modport slave (
      input  start, dl_out, ready,
      output busy, launch, result, overflow, valid, meas_cnt
   );
endinterface

// File: rtl/tdc_ctrl.sv
// Time-to-digital converter controller: fires the delay line, synchronizes the
// tap snapshot, thermometer-decodes it by popcount and hands it to a consumer.
//
// state  | meaning
// IDLE   | waiting for start; launch low
// LAUNCH | launch high for one cycle; tap snapshot enters sync stage 0
// SYNC   | snapshot shifted through the remaining synchronizer stages
// ENCODE | popcount of final stage loaded into result/overflow; valid set
// HOLD   | valid high until ready; launch still high
// DRAIN  | launch low for DRAIN_CYC cycles so the delay line settles
module tdc_ctrl #(
   parameter int N           = 64,
   parameter int SYNC_STAGES = 2,
   parameter int DRAIN_CYC   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   tdc_ctrl_if.slave   bus
);
   localparam int RW   = $clog2(N + 1);
   localparam int SC_W = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES - 1) : 1;
   localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [SC_W-1:0] SYNC_LOAD  = SC_W'((SYNC_STAGES >= 2) ? SYNC_STAGES - 2 : 0);
   localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      SYNC   = 3'd2,
      ENCODE = 3'd3,
      HOLD   = 3'd4,
      DRAIN  = 3'd5
   } state_t;

   state_t          state_q;
   logic            launch_q;
   logic            valid_q;
   logic            overflow_q;
   logic [RW-1:0]   result_q;
   logic [15:0]     meas_cnt_q;
   logic [SC_W-1:0] sync_cnt_q;
   logic [DC_W-1:0] drain_cnt_q;
   logic [N-1:0]    sync_q [SYNC_STAGES];
   logic [RW-1:0]   pop_d;

   // Counting set taps rather than locating the first zero tolerates bubbles.
   function automatic logic [RW-1:0] popcount(input logic [N-1:0] v);
      logic [RW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + RW'(v[i]);
      end
      return c;
   endfunction

   assign pop_d = popcount(sync_q[SYNC_STAGES-1]);

   // Stage 0 samples every cycle; later stages only advance while in SYNC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.dl_out;
         if (state_q == SYNC) begin
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_q[i] <= sync_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         launch_q    <= 1'b0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         result_q    <= '0;
         meas_cnt_q  <= '0;
         sync_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q  <= LAUNCH;
                  launch_q <= 1'b1;
               end
            end
            LAUNCH: begin
               if (SYNC_STAGES == 1) begin
                  state_q <= ENCODE;
               end else begin
                  state_q    <= SYNC;
                  sync_cnt_q <= SYNC_LOAD;
               end
            end
            SYNC: begin
               if (sync_cnt_q == '0) begin
                  state_q <= ENCODE;
               end else begin
                  sync_cnt_q <= sync_cnt_q - 1'b1;
               end
            end
            ENCODE: begin
               result_q   <= pop_d;
               overflow_q <= (pop_d == RW'(N));
               valid_q    <= 1'b1;
               state_q    <= HOLD;
            end
            HOLD: begin
               if (bus.ready) begin
                  valid_q     <= 1'b0;
                  launch_q    <= 1'b0;
                  meas_cnt_q  <= meas_cnt_q + 16'd1;
                  drain_cnt_q <= DRAIN_LOAD;
                  state_q     <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_cnt_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  drain_cnt_q <= drain_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               launch_q <= 1'b0;
               valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.launch   = launch_q;
   assign bus.valid    = valid_q;
   assign bus.result   = result_q;
   assign bus.overflow = overflow_q;
   assign bus.meas_cnt = meas_cnt_q;
endmodule
